// File: rtl/miriscv_pkg.sv
// -----------------------------------------------------------------------------
// miriscv_pkg
// Shared definitions for the miriscv memory arbiter: machine word width,
// byte-enable width, the arbiter FSM state type and the port-owner type.
// -----------------------------------------------------------------------------
package miriscv_pkg;

   localparam int XLEN = 32;
   localparam int BE_W = XLEN / 8;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_WAIT_GNT    = 2'd1,
      ST_WAIT_RVALID = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_INSTR = 1'b0,
      OWN_DATA  = 1'b1
   } arb_owner_e;

endpackage

// File: rtl/miriscv_arb_select.sv
// -----------------------------------------------------------------------------
// miriscv_arb_select
// Combinational owner choice between the fetch and LSU requesters.
//   instr_req_i    : fetch request pending
//   data_req_i     : LSU request pending
//   prefer_data_i  : tie-break when both request (1 = LSU wins)
//   owner_o        : selected owner (only meaningful when a request is pending)
// The caller ties prefer_data_i high for fixed data priority, or drives it
// from a round-robin pointer.
// -----------------------------------------------------------------------------
module miriscv_arb_select
   import miriscv_pkg::*;
(
   input  logic       instr_req_i,
   input  logic       data_req_i,
   input  logic       prefer_data_i,
   output arb_owner_e owner_o
);

   // NOTE: a default assignment at the top of always_comb prevents latch
   // inference on any path that does not write the signal.
   always_comb begin
      owner_o = OWN_INSTR;
      if (data_req_i && (!instr_req_i || prefer_data_i)) begin
         owner_o = OWN_DATA;
      end
   end

endmodule

// File: rtl/miriscv_mem_arbiter.sv
// -----------------------------------------------------------------------------
// miriscv_mem_arbiter
// Shares one memory port between the instruction fetch and the LSU, with at
// most one transaction outstanding.
//   clk_i, arstn_i          : clock, asynchronous active-low reset
//   instr_req_i/addr_i      : fetch request (held until instr_rvalid_o)
//   instr_flush_i           : discard the outstanding fetch response
//   instr_rvalid_o/rdata_o  : fetch response
//   data_req_i/we/be/addr/wdata : LSU request (held until data_rvalid_o)
//   data_rvalid_o/rdata_o   : LSU response (also pulses for writes)
//   mem_req/we/be/addr/wdata_o : registered shared-port request
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i : shared-port handshake / response
// Build option: define MIRISCV_ARB_RR_EN for round-robin arbitration; the
// default build uses fixed data-over-fetch priority and has no pointer flop.
// -----------------------------------------------------------------------------
module miriscv_mem_arbiter
   import miriscv_pkg::*;
(
   input  logic            clk_i,
   input  logic            arstn_i,
   input  logic            instr_req_i,
   input  logic [XLEN-1:0] instr_addr_i,
   input  logic            instr_flush_i,
   output logic            instr_rvalid_o,
   output logic [XLEN-1:0] instr_rdata_o,
   input  logic            data_req_i,
   input  logic            data_we_i,
   input  logic [BE_W-1:0] data_be_i,
   input  logic [XLEN-1:0] data_addr_i,
   input  logic [XLEN-1:0] data_wdata_i,
   output logic            data_rvalid_o,
   output logic [XLEN-1:0] data_rdata_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [BE_W-1:0] mem_be_o,
   output logic [XLEN-1:0] mem_addr_o,
   output logic [XLEN-1:0] mem_wdata_o,
   input  logic            mem_gnt_i,
   input  logic            mem_rvalid_i,
   input  logic [XLEN-1:0] mem_rdata_i
);

   arb_state_e      state_q, state_d;
   arb_owner_e      owner_q, owner_d;
   logic            drop_q, drop_d;
   logic            mem_req_q, mem_req_d;
   logic            mem_we_q, mem_we_d;
   logic [BE_W-1:0] mem_be_q, mem_be_d;
   logic [XLEN-1:0] mem_addr_q, mem_addr_d;
   logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;

   arb_owner_e      sel_owner;
   logic            prefer_data;
   logic            any_req;
   logic            flush_hit;
   logic            resp_fire;

   assign any_req   = instr_req_i || data_req_i;
   assign flush_hit = instr_flush_i && (owner_q == OWN_INSTR);
   assign resp_fire = (state_q == ST_WAIT_RVALID) && mem_rvalid_i;

`ifdef MIRISCV_ARB_RR_EN
   // Pointer set means "favour data next"; it points away from the port
   // selected last, so it resets to favour fetch.
   logic rr_q, rr_d;

   assign prefer_data = rr_q;

   always_comb begin
      rr_d = rr_q;
      if ((state_q == ST_IDLE) && any_req) begin
         rr_d = (sel_owner == OWN_INSTR);
      end
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         rr_q <= 1'b0;
      end else begin
         rr_q <= rr_d;
      end
   end
`else
   assign prefer_data = 1'b1;
`endif

   miriscv_arb_select u_arb_select (
      .instr_req_i   (instr_req_i),
      .data_req_i    (data_req_i),
      .prefer_data_i (prefer_data),
      .owner_o       (sel_owner)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      drop_d      = drop_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      case (state_q)
         ST_IDLE: begin
            drop_d = 1'b0;
            if (any_req) begin
               owner_d   = sel_owner;
               mem_req_d = 1'b1;
               state_d   = ST_WAIT_GNT;
               if (sel_owner == OWN_DATA) begin
                  mem_we_d    = data_we_i;
                  mem_be_d    = data_be_i;
                  mem_addr_d  = data_addr_i;
                  mem_wdata_d = data_wdata_i;
               end else begin
                  mem_we_d    = 1'b0;
                  mem_be_d    = '1;
                  mem_addr_d  = instr_addr_i;
                  mem_wdata_d = '0;
               end
            end
         end
         ST_WAIT_GNT: begin
            if (mem_gnt_i) begin
               mem_req_d = 1'b0;
               state_d   = ST_WAIT_RVALID;
            end
            if (flush_hit) begin
               drop_d = 1'b1;
            end
         end
         ST_WAIT_RVALID: begin
            if (mem_rvalid_i) begin
               state_d = ST_IDLE;
               drop_d  = 1'b0;
            end else if (flush_hit) begin
               drop_d = 1'b1;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before the edge, independent of statement order.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWN_INSTR;
         drop_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         drop_q      <= drop_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_be_o    = mem_be_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;

   // A flush arriving in the response cycle suppresses the pulse just like
   // an earlier flush captured in drop_q.
   assign instr_rvalid_o = resp_fire && (owner_q == OWN_INSTR) && !drop_q && !instr_flush_i;
   assign data_rvalid_o  = resp_fire && (owner_q == OWN_DATA);
   assign instr_rdata_o  = mem_rdata_i;
   assign data_rdata_o   = mem_rdata_i;

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_miriscv_mem_arbiter
// Directed bench for miriscv_mem_arbiter. Expected memory transactions are
// queued when requests are raised and checked when mem_req_o appears; a small
// arbitration model (fixed priority or round-robin, following
// MIRISCV_ARB_RR_EN) predicts the grant order.
// -----------------------------------------------------------------------------
module tb_miriscv_mem_arbiter;
   import miriscv_pkg::*;

`ifdef MIRISCV_ARB_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   typedef struct {
      arb_owner_e      owner;
      logic [XLEN-1:0] addr;
      logic            we;
      logic [BE_W-1:0] be;
      logic [XLEN-1:0] wdata;
   } txn_t;

   logic            clk_i;
   logic            arstn_i;
   logic            instr_req_i;
   logic [XLEN-1:0] instr_addr_i;
   logic            instr_flush_i;
   logic            instr_rvalid_o;
   logic [XLEN-1:0] instr_rdata_o;
   logic            data_req_i;
   logic            data_we_i;
   logic [BE_W-1:0] data_be_i;
   logic [XLEN-1:0] data_addr_i;
   logic [XLEN-1:0] data_wdata_i;
   logic            data_rvalid_o;
   logic [XLEN-1:0] data_rdata_o;
   logic            mem_req_o;
   logic            mem_we_o;
   logic [BE_W-1:0] mem_be_o;
   logic [XLEN-1:0] mem_addr_o;
   logic [XLEN-1:0] mem_wdata_o;
   logic            mem_gnt_i;
   logic            mem_rvalid_i;
   logic [XLEN-1:0] mem_rdata_i;

   int   checks = 0;
   int   errors = 0;
   txn_t exp_q[$];
   bit   rr_fav_data = 1'b0;

   miriscv_mem_arbiter dut (
      .clk_i          (clk_i),
      .arstn_i        (arstn_i),
      .instr_req_i    (instr_req_i),
      .instr_addr_i   (instr_addr_i),
      .instr_flush_i  (instr_flush_i),
      .instr_rvalid_o (instr_rvalid_o),
      .instr_rdata_o  (instr_rdata_o),
      .data_req_i     (data_req_i),
      .data_we_i      (data_we_i),
      .data_be_i      (data_be_i),
      .data_addr_i    (data_addr_i),
      .data_wdata_i   (data_wdata_i),
      .data_rvalid_o  (data_rvalid_o),
      .data_rdata_o   (data_rdata_o),
      .mem_req_o      (mem_req_o),
      .mem_we_o       (mem_we_o),
      .mem_be_o       (mem_be_o),
      .mem_addr_o     (mem_addr_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_gnt_i      (mem_gnt_i),
      .mem_rvalid_i   (mem_rvalid_i),
      .mem_rdata_i    (mem_rdata_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [XLEN-1:0] observed,
                        input logic [XLEN-1:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic arb_owner_e pick(input bit i_req, input bit d_req);
      if (i_req && d_req) return (!RR_EN || rr_fav_data) ? OWN_DATA : OWN_INSTR;
      if (d_req) return OWN_DATA;
      return OWN_INSTR;
   endfunction

   task automatic push_instr(input logic [XLEN-1:0] addr);
      txn_t t;
      t.owner = OWN_INSTR;
      t.addr  = addr;
      t.we    = 1'b0;
      t.be    = '1;
      t.wdata = '0;
      exp_q.push_back(t);
      rr_fav_data = 1'b1;
   endtask

   task automatic push_data(input logic we, input logic [BE_W-1:0] be,
                            input logic [XLEN-1:0] addr, input logic [XLEN-1:0] wdata);
      txn_t t;
      t.owner = OWN_DATA;
      t.addr  = addr;
      t.we    = we;
      t.be    = be;
      t.wdata = wdata;
      exp_q.push_back(t);
      rr_fav_data = 1'b0;
   endtask

   // One memory-side transaction. flush_mode: 0 none, 1 flush in WAIT_GNT,
   // 2 flush in WAIT_RVALID before the response, 3 flush with the response.
   task automatic mem_txn(input int gnt_wait, input int rv_wait, input logic [XLEN-1:0] rdata,
                          input int flush_mode, input bit drop_req);
      txn_t e;
      int   n;
      bit   exp_i;
      bit   exp_d;
      n = 0;
      while (mem_req_o !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      if (mem_req_o !== 1'b1) begin
         check("req_timeout", {31'd0, mem_req_o}, 32'd1);
         return;
      end
      if (exp_q.size() == 0) begin
         check("sb_empty_addr", mem_addr_o, 32'hFFFF_FFFF);
         return;
      end
      e = exp_q.pop_front();
      check("mem_addr", mem_addr_o, e.addr);
      check("mem_we", {31'd0, mem_we_o}, {31'd0, e.we});
      check("mem_be", {28'd0, mem_be_o}, {28'd0, e.be});
      check("mem_wdata", mem_wdata_o, e.wdata);
      for (int i = 0; i < gnt_wait; i++) begin
         if (flush_mode == 1 && i == 0) instr_flush_i = 1'b1;
         tick();
         instr_flush_i = 1'b0;
         check("req_hold", {31'd0, mem_req_o}, 32'd1);
      end
      check("addr_hold", mem_addr_o, e.addr);
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i = 1'b0;
      check("req_drop", {31'd0, mem_req_o}, 32'd0);
      for (int i = 0; i < rv_wait; i++) begin
         if (flush_mode == 2 && i == 0) instr_flush_i = 1'b1;
         tick();
         instr_flush_i = 1'b0;
         check("no_early_rvalid", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
      end
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = rdata;
      if (flush_mode == 3) instr_flush_i = 1'b1;
      #1;
      exp_i = (e.owner == OWN_INSTR) && (flush_mode == 0);
      exp_d = (e.owner == OWN_DATA);
      check("instr_rvalid", {31'd0, instr_rvalid_o}, {31'd0, exp_i});
      check("data_rvalid", {31'd0, data_rvalid_o}, {31'd0, exp_d});
      check("instr_rdata", instr_rdata_o, rdata);
      check("data_rdata", data_rdata_o, rdata);
      tick();
      mem_rvalid_i  = 1'b0;
      instr_flush_i = 1'b0;
      if (drop_req) begin
         if (e.owner == OWN_INSTR) instr_req_i = 1'b0;
         else data_req_i = 1'b0;
      end
   endtask

   initial begin
      arb_owner_e o;
      arstn_i       = 1'b0;
      instr_req_i   = 1'b0;
      instr_addr_i  = '0;
      instr_flush_i = 1'b0;
      data_req_i    = 1'b0;
      data_we_i     = 1'b0;
      data_be_i     = '0;
      data_addr_i   = '0;
      data_wdata_i  = '0;
      mem_gnt_i     = 1'b0;
      mem_rvalid_i  = 1'b0;
      mem_rdata_i   = '0;
      #1;
      check("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
      check("rst_mem_addr", mem_addr_o, 32'd0);
      check("rst_mem_be", {28'd0, mem_be_o}, 32'd0);
      check("rst_rvalid", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
      repeat (2) @(posedge clk_i);
      #1;
      arstn_i = 1'b1;
      tick();

      // Fetch-only: one-cycle request latency, gnt after 2 cycles, rvalid 1 later.
      push_instr(32'h0000_0100);
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h0000_0100;
      #1;
      check("req_latency_same_cycle", {31'd0, mem_req_o}, 32'd0);
      tick();
      check("req_latency_next_cycle", {31'd0, mem_req_o}, 32'd1);
      mem_txn(2, 1, 32'h0000_0013, 0, 1'b1);

      // Simultaneous data write and fetch.
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h0000_0104;
      data_req_i   = 1'b1;
      data_we_i    = 1'b1;
      data_be_i    = 4'hF;
      data_addr_i  = 32'h0000_2000;
      data_wdata_i = 32'hDEAD_BEEF;
      o = pick(1'b1, 1'b1);
      if (o == OWN_DATA) begin
         push_data(1'b1, 4'hF, 32'h0000_2000, 32'hDEAD_BEEF);
         push_instr(32'h0000_0104);
      end else begin
         push_instr(32'h0000_0104);
         push_data(1'b1, 4'hF, 32'h0000_2000, 32'hDEAD_BEEF);
      end
      mem_txn(1, 0, 32'h1111_2222, 0, 1'b1);
      mem_txn(0, 2, 32'h0000_0017, 0, 1'b1);

      // Flush in WAIT_RVALID drops the response; the next fetch is normal.
      push_instr(32'h0000_0108);
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h0000_0108;
      mem_txn(1, 2, 32'hFFFF_FFFF, 2, 1'b1);
      push_instr(32'h0000_010C);
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h0000_010C;
      mem_txn(0, 0, 32'h0000_0093, 0, 1'b1);

      // Flush coincident with the response.
      push_instr(32'h0000_0110);
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h0000_0110;
      mem_txn(0, 1, 32'hCAFE_0001, 3, 1'b1);

      // Flush during WAIT_GNT.
      push_instr(32'h0000_0114);
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h0000_0114;
      mem_txn(2, 0, 32'hCAFE_0002, 1, 1'b1);

      // Flush in IDLE, coincident with the accepting cycle, has no effect.
      push_instr(32'h0000_0118);
      instr_req_i   = 1'b1;
      instr_addr_i  = 32'h0000_0118;
      instr_flush_i = 1'b1;
      tick();
      instr_flush_i = 1'b0;
      mem_txn(0, 0, 32'h0000_0033, 0, 1'b1);

      // Flush with a data owner has no effect.
      push_data(1'b0, 4'h3, 32'h0000_3000, 32'h0000_0000);
      data_req_i   = 1'b1;
      data_we_i    = 1'b0;
      data_be_i    = 4'h3;
      data_addr_i  = 32'h0000_3000;
      data_wdata_i = 32'h0000_0000;
      mem_txn(1, 2, 32'h0000_55AA, 2, 1'b1);

      // Both requests held across four transactions, then data drops.
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h0000_0200;
      data_req_i   = 1'b1;
      data_we_i    = 1'b0;
      data_be_i    = 4'h3;
      data_addr_i  = 32'h0000_4000;
      data_wdata_i = 32'h0000_0000;
      for (int k = 0; k < 4; k++) begin
         o = pick(1'b1, 1'b1);
         if (o == OWN_DATA) push_data(1'b0, 4'h3, 32'h0000_4000, 32'h0000_0000);
         else push_instr(32'h0000_0200);
      end
      push_instr(32'h0000_0200);
      for (int k = 0; k < 4; k++) begin
         mem_txn(0, 0, 32'h0000_0A00 + k, 0, (k == 3));
      end
      mem_txn(0, 0, 32'h0000_0A04, 0, 1'b1);

      // Reset during WAIT_GNT, then a stray response and grant.
      push_instr(32'h0000_0300);
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h0000_0300;
      tick();
      tick();
      check("pre_reset_req", {31'd0, mem_req_o}, 32'd1);
      if (exp_q.size() != 0) begin
         txn_t e;
         e = exp_q.pop_front();
         check("pre_reset_addr", mem_addr_o, e.addr);
      end
      arstn_i     = 1'b0;
      instr_req_i = 1'b0;
      rr_fav_data = 1'b0;
      #1;
      check("reset_req_immediate", {31'd0, mem_req_o}, 32'd0);
      check("reset_addr_immediate", mem_addr_o, 32'd0);
      tick();
      arstn_i = 1'b1;
      tick();
      mem_rvalid_i = 1'b1;
      mem_gnt_i    = 1'b1;
      mem_rdata_i  = 32'h0BAD_0BAD;
      #1;
      check("stray_rvalid", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
      tick();
      mem_rvalid_i = 1'b0;
      mem_gnt_i    = 1'b0;
      check("stray_gnt_req", {31'd0, mem_req_o}, 32'd0);

      push_instr(32'h0000_0120);
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h0000_0120;
      mem_txn(1, 1, 32'h0000_0073, 0, 1'b1);
      check("sb_drained", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/miriscv_mem_arbiter.md
MIRISCV_MEM_ARBITER -- requirements
Module: miriscv_mem_arbiter

Interface
REQ-001 Parameters: none; XLEN SHALL come from miriscv_pkg.
REQ-002 clk_i  in  1  core clock, all state on rising edge.
REQ-003 arstn_i  in  1  asynchronous active-low reset.
REQ-004 instr_req_i  in  1  fetch request, held high until instr_rvalid_o.
REQ-005 instr_addr_i  in  XLEN  fetch address.
REQ-006 instr_flush_i  in  1  discard any outstanding fetch response.
REQ-007 instr_rvalid_o  out  1  fetch response valid, one-cycle pulse.
REQ-008 instr_rdata_o  out  XLEN  fetch response data.
REQ-009 data_req_i  in  1  LSU request, held high until data_rvalid_o.
REQ-010 data_we_i  in  1  1 = write, 0 = read.
REQ-011 data_be_i  in  XLEN/8  byte enables.
REQ-012 data_addr_i  in  XLEN  LSU address.
REQ-013 data_wdata_i  in  XLEN  write data.
REQ-014 data_rvalid_o  out  1  LSU response valid, one-cycle pulse, also for writes.
REQ-015 data_rdata_o  out  XLEN  LSU read data.
REQ-016 mem_req_o  out  1  shared-port request.
REQ-017 mem_we_o  out  1  write enable.
REQ-018 mem_be_o  out  XLEN/8  byte enables.
REQ-019 mem_addr_o  out  XLEN  address.
REQ-020 mem_wdata_o  out  XLEN  write data.
REQ-021 mem_gnt_i  in  1  memory accepted request.
REQ-022 mem_rvalid_i  in  1  memory response valid.
REQ-023 mem_rdata_i  in  XLEN  memory response data.

Function
REQ-024 The FSM SHALL have states IDLE, WAIT_GNT and WAIT_RVALID, with one outstanding transaction at most.
REQ-025 In IDLE with any request, the block SHALL select an owner, register addr/we/be/wdata into the mem_* outputs, and enter WAIT_GNT; mem_req_o rises the next cycle, one cycle after the request.
REQ-026 Fetch requests SHALL register as we=0 and be=all-ones, with wdata zero.
REQ-027 The default arbitration SHALL give data priority over fetch when both requests are high in the same IDLE cycle.
REQ-028 In WAIT_GNT, mem_req_o and the registered fields SHALL stay stable until mem_gnt_i; on gnt, mem_req_o drops the next cycle and the FSM enters WAIT_RVALID.
REQ-029 In WAIT_RVALID, on mem_rvalid_i, the owner's rvalid_o SHALL pulse combinationally in the same cycle with rdata_o = mem_rdata_i, and the FSM returns to IDLE.
REQ-030 A new request SHALL be accepted no earlier than the cycle after the response.
REQ-031 The non-owner rvalid_o SHALL remain 0, and rdata_o of both ports SHALL be mem_rdata_i.
REQ-032 instr_flush_i high while the fetch owns the port, in WAIT_GNT or WAIT_RVALID, SHALL set a drop flag; the request is not retracted, and the response completes the FSM sequence with instr_rvalid_o held at 0.
REQ-033 Flush coincident with mem_rvalid_i SHALL suppress that pulse.
REQ-034 Flush in IDLE or with a data owner SHALL have no effect.
REQ-035 The drop flag SHALL clear on return to IDLE.
REQ-036 mem_rvalid_i outside WAIT_RVALID SHALL be ignored.
REQ-037 mem_gnt_i outside WAIT_GNT SHALL be ignored.

Reset
REQ-038 arstn_i low SHALL immediately force the FSM to IDLE, clear the owner, drop flag and round-robin pointer, and zero all mem_* outputs; both rvalid_o outputs are 0.
REQ-039 A transaction in flight at reset SHALL be abandoned, and its late response SHALL be ignored per REQ-036.

Configuration
REQ-040 With MIRISCV_ARB_RR_EN defined, arbitration SHALL be round-robin: a 1-bit pointer favours the port not granted last, it updates on each IDLE selection, and it resets to favour fetch.
REQ-041 Without MIRISCV_ARB_RR_EN, arbitration SHALL be fixed data priority per REQ-027, and no pointer flop is built.

Structure
REQ-042 miriscv_pkg SHALL hold the FSM state enum typedef and the owner enum typedef (OWN_INSTR, OWN_DATA).
REQ-043 A single sub-module miriscv_arb_select SHALL implement the combinational priority/round-robin choice.
REQ-044 The FSM and registers SHALL reside in the top module.

Verification
REQ-045 Fetch-only, addr 0x0000_0100, gnt after 2 cycles, rvalid after 1 more with rdata 0x0000_0013 -> instr_rvalid_o pulses once with 0x0000_0013; mem_we_o=0, mem_be_o all-ones.
REQ-046 Both requests in the same IDLE cycle, data write to 0x0000_2000 with wdata 0xDEAD_BEEF and be 0xF -> first mem transaction is the write, fetch is served afterwards; data_rvalid_o precedes instr_rvalid_o.
REQ-047 Flush while the fetch is in WAIT_RVALID, then rvalid with rdata 0xFFFF_FFFF -> instr_rvalid_o stays 0, the FSM returns to IDLE, and the next fetch completes normally.
REQ-048 With MIRISCV_ARB_RR_EN, both requests held continuously for 4 transactions -> grant order is instr, data, instr, data; without the macro, data is granted every time while data_req_i is high.
REQ-049 arstn_i pulsed low during WAIT_GNT -> mem_req_o is 0 at once; a stray mem_rvalid_i after release produces no rvalid_o pulse.
